// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the fetch-stage program-counter generator.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package pc_gen_pkg;

  // Fetch-sequencer states: BOOT lasts one cycle after reset before fetching starts.
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  // Exception cause codes reported on exc_code.
  localparam logic [1:0] EXC_NONE = 2'd0;
  localparam logic [1:0] EXC_EXT  = 2'd1;
  localparam logic [1:0] EXC_ADEL = 2'd2;

  // Sequential fetch stride in bytes.
  localparam int PC_INC = 4;

  // A redirect target is misaligned when either of its two low bits is set.
  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return (low_bits != 2'b00);
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Priority mux choosing the next fetch address and exception side effects.
// Latency: purely combinational, results are registered by the pc_gen top.
// Backpressure: fetch_ready/stall only gate sequential advance, never redirects.
module pc_next_sel
  import pc_gen_pkg::*;
#(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] EXC_VEC = WIDTH'(32'h0000_4180)
) (
  input  logic [1:0]       state,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] epc,
  input  logic             fetch_ready,
  input  logic             stall,
  input  logic             br_valid,
  input  logic [WIDTH-1:0] br_target,
  input  logic             exc_req,
  input  logic             eret,
  input  logic             halt_req,
  input  logic             resume,
  output logic [WIDTH-1:0] pc_nxt,
  output logic             epc_ld,
  output logic             badvaddr_ld,
  output logic             exc_ld,
  output logic [1:0]       exc_code_nxt,
  output logic             halt_sel,
  output logic             run_sel
);

  logic br_misaligned;
  logic [WIDTH-1:0] pc_seq;

  assign br_misaligned = is_misaligned(br_target[1:0]);
  // Sequential advance wraps naturally at 2^WIDTH.
  assign pc_seq        = pc + WIDTH'(PC_INC);

  // Fixed-priority selection: exception > eret > misaligned branch > branch > halt > advance.
  always_comb begin
    pc_nxt       = pc;
    epc_ld       = 1'b0;
    badvaddr_ld  = 1'b0;
    exc_ld       = 1'b0;
    exc_code_nxt = EXC_NONE;
    halt_sel     = 1'b0;
    run_sel      = 1'b0;
    case (state)
      RUN: begin
        if (exc_req) begin
          pc_nxt       = EXC_VEC;
          epc_ld       = 1'b1;
          exc_ld       = 1'b1;
          exc_code_nxt = EXC_EXT;
        end else if (eret) begin
          pc_nxt = epc;
        end else if (br_valid && br_misaligned) begin
          pc_nxt       = EXC_VEC;
          epc_ld       = 1'b1;
          badvaddr_ld  = 1'b1;
          exc_ld       = 1'b1;
          exc_code_nxt = EXC_ADEL;
        end else if (br_valid) begin
          pc_nxt = br_target;
        end else if (halt_req) begin
          halt_sel = 1'b1;
        end else if (fetch_ready && !stall) begin
          pc_nxt = pc_seq;
        end
      end
      HALT: begin
        // Only an exception or resume can wake the fetch unit; redirects are ignored here.
        if (exc_req) begin
          pc_nxt       = EXC_VEC;
          epc_ld       = 1'b1;
          exc_ld       = 1'b1;
          exc_code_nxt = EXC_EXT;
          run_sel      = 1'b1;
        end else if (resume) begin
          run_sel = 1'b1;
        end
      end
      default: begin
        // BOOT ignores every request; pc is simply held.
      end
    endcase
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program counter with redirect, exception, ERET and halt support.
// Latency: every output is registered; redirects are visible one cycle later.
// Backpressure: pc advances only when fetch_ready and not stall; unaccepted fetches drop on redirect.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(32'h0000_3000),
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(32'h0000_4180)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_ready,
  input  logic             stall,
  input  logic             br_valid,
  input  logic [WIDTH-1:0] br_target,
  input  logic             exc_req,
  input  logic             eret,
  input  logic             halt_req,
  input  logic             resume,
  output logic [WIDTH-1:0] pc,
  output logic             pc_valid,
  output logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] badvaddr,
  output logic             exc_taken,
  output logic [1:0]       exc_code,
  output logic             halted
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             pc_valid_q, pc_valid_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic [WIDTH-1:0] badvaddr_q, badvaddr_d;
  logic             exc_taken_q, exc_taken_d;
  logic [1:0]       exc_code_q, exc_code_d;
  logic             halted_q, halted_d;

  logic [WIDTH-1:0] sel_pc;
  logic             sel_epc_ld;
  logic             sel_badvaddr_ld;
  logic             sel_exc_ld;
  logic [1:0]       sel_exc_code;
  logic             sel_halt;
  logic             sel_run;

  pc_next_sel #(
    .WIDTH   (WIDTH),
    .EXC_VEC (EXC_VEC)
  ) u_next_sel (
    .state        (state_q),
    .pc           (pc_q),
    .epc          (epc_q),
    .fetch_ready  (fetch_ready),
    .stall        (stall),
    .br_valid     (br_valid),
    .br_target    (br_target),
    .exc_req      (exc_req),
    .eret         (eret),
    .halt_req     (halt_req),
    .resume       (resume),
    .pc_nxt       (sel_pc),
    .epc_ld       (sel_epc_ld),
    .badvaddr_ld  (sel_badvaddr_ld),
    .exc_ld       (sel_exc_ld),
    .exc_code_nxt (sel_exc_code),
    .halt_sel     (sel_halt),
    .run_sel      (sel_run)
  );

  // Next-state and next-output computation; pc_valid/halted follow the next state directly.
  always_comb begin
    state_d     = state_q;
    pc_d        = sel_pc;
    epc_d       = epc_q;
    badvaddr_d  = badvaddr_q;
    exc_taken_d = 1'b0;
    exc_code_d  = exc_code_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (sel_halt) state_d = HALT;
      HALT:    if (sel_run)  state_d = RUN;
      default: state_d = BOOT;
    endcase
    if (sel_epc_ld) begin
      epc_d = pc_q;
    end
    if (sel_badvaddr_ld) begin
      badvaddr_d = br_target;
    end
    if (sel_exc_ld) begin
      exc_taken_d = 1'b1;
      exc_code_d  = sel_exc_code;
    end
    pc_valid_d = (state_d == RUN);
    halted_d   = (state_d == HALT);
  end

  // State and output registers with synchronous reset overriding every input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= BOOT;
      pc_q        <= RESET_VEC;
      pc_valid_q  <= 1'b0;
      epc_q       <= '0;
      badvaddr_q  <= '0;
      exc_taken_q <= 1'b0;
      exc_code_q  <= EXC_NONE;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pc_valid_q  <= pc_valid_d;
      epc_q       <= epc_d;
      badvaddr_q  <= badvaddr_d;
      exc_taken_q <= exc_taken_d;
      exc_code_q  <= exc_code_d;
      halted_q    <= halted_d;
    end
  end

  assign pc        = pc_q;
  assign pc_valid  = pc_valid_q;
  assign epc       = epc_q;
  assign badvaddr  = badvaddr_q;
  assign exc_taken = exc_taken_q;
  assign exc_code  = exc_code_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: a 32-bit instance and an 8-bit wrap-around instance.
// Latency: expectations are queued at the negedge and compared after the next posedge.
// Backpressure: fetch_ready and stall are driven directly by the stimulus vectors.
module tb_pc_gen;

  localparam int OP_F   = 1;    // fetch_ready
  localparam int OP_S   = 2;    // stall
  localparam int OP_B   = 4;    // br_valid
  localparam int OP_X   = 8;    // exc_req
  localparam int OP_E   = 16;   // eret
  localparam int OP_H   = 32;   // halt_req
  localparam int OP_R   = 64;   // resume
  localparam int OP_RST = 128;  // reset

  typedef struct {
    logic [31:0] pc;
    logic        v;
    logic [31:0] epc;
    logic [31:0] bad;
    logic        tk;
    logic [1:0]  code;
    logic        h;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset32 = 1'b1;
  logic        reset8  = 1'b1;
  logic        fetch_ready = 1'b0, stall = 1'b0, br_valid = 1'b0;
  logic        exc_req = 1'b0, eret = 1'b0, halt_req = 1'b0, resume = 1'b0;
  logic [31:0] br_target32 = '0;
  logic [7:0]  br_target8  = '0;

  logic [31:0] pc32, epc32, bad32;
  logic        v32, tk32, h32;
  logic [1:0]  code32;
  logic [7:0]  pc8, epc8, bad8;
  logic        v8, tk8, h8;
  logic [1:0]  code8;

  pc_gen dut32 (
    .clk(clk), .reset(reset32), .fetch_ready(fetch_ready), .stall(stall),
    .br_valid(br_valid), .br_target(br_target32), .exc_req(exc_req), .eret(eret),
    .halt_req(halt_req), .resume(resume), .pc(pc32), .pc_valid(v32), .epc(epc32),
    .badvaddr(bad32), .exc_taken(tk32), .exc_code(code32), .halted(h32)
  );

  pc_gen #(.WIDTH(8), .RESET_VEC(8'hFC)) dut8 (
    .clk(clk), .reset(reset8), .fetch_ready(fetch_ready), .stall(stall),
    .br_valid(br_valid), .br_target(br_target8), .exc_req(exc_req), .eret(eret),
    .halt_req(halt_req), .resume(resume), .pc(pc8), .pc_valid(v8), .epc(epc8),
    .badvaddr(bad8), .exc_taken(tk8), .exc_code(code8), .halted(h8)
  );

  exp_t q32[$];
  exp_t q8[$];
  int checks = 0;
  int errors = 0;

  // Sticky expected values, updated by hand where the sequence takes an exception.
  logic [31:0] g_epc = '0, g_bad = '0;
  logic [1:0]  g_code = 2'd0;

  task automatic chk(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, tag, act, exp);
    end
  endtask

  task automatic apply(input int op);
    fetch_ready = op[0];
    stall       = op[1];
    br_valid    = op[2];
    exc_req     = op[3];
    eret        = op[4];
    halt_req    = op[5];
    resume      = op[6];
  endtask

  task automatic step32(input int op, input logic [31:0] bt, input logic [31:0] e_pc,
                        input logic e_v, input logic e_tk, input logic e_h);
    @(negedge clk);
    apply(op);
    br_target32 = bt;
    reset32     = op[7];
    reset8      = 1'b1;
    q32.push_back('{pc: e_pc, v: e_v, epc: g_epc, bad: g_bad, tk: e_tk, code: g_code, h: e_h});
  endtask

  task automatic step8(input int op, input logic [7:0] bt, input logic [7:0] e_pc,
                       input logic e_v, input logic e_tk, input logic e_h);
    @(negedge clk);
    apply(op);
    br_target8 = bt;
    reset8     = op[7];
    reset32    = 1'b1;
    q8.push_back('{pc: {24'h0, e_pc}, v: e_v, epc: g_epc, bad: g_bad, tk: e_tk, code: g_code, h: e_h});
  endtask

  int n32 = 0;
  int n8  = 0;

  // Monitor for the 32-bit instance: one expectation per clock after it is queued.
  always @(posedge clk) begin
    #1;
    if (q32.size() > 0) begin
      exp_t e;
      e = q32.pop_front();
      n32++;
      chk("pc32",        n32, pc32,            e.pc);
      chk("pc_valid32",  n32, {31'h0, v32},    {31'h0, e.v});
      chk("epc32",       n32, epc32,           e.epc);
      chk("badvaddr32",  n32, bad32,           e.bad);
      chk("exc_taken32", n32, {31'h0, tk32},   {31'h0, e.tk});
      chk("exc_code32",  n32, {30'h0, code32}, {30'h0, e.code});
      chk("halted32",    n32, {31'h0, h32},    {31'h0, e.h});
    end
  end

  // Monitor for the 8-bit instance.
  always @(posedge clk) begin
    #1;
    if (q8.size() > 0) begin
      exp_t e;
      e = q8.pop_front();
      n8++;
      chk("pc8",        n8, {24'h0, pc8},   e.pc);
      chk("pc_valid8",  n8, {31'h0, v8},    {31'h0, e.v});
      chk("epc8",       n8, {24'h0, epc8},  e.epc);
      chk("badvaddr8",  n8, {24'h0, bad8},  e.bad);
      chk("exc_taken8", n8, {31'h0, tk8},   {31'h0, e.tk});
      chk("exc_code8",  n8, {30'h0, code8}, {30'h0, e.code});
      chk("halted8",    n8, {31'h0, h8},    {31'h0, e.h});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected completion before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset, BOOT cycle with pc_valid low, then sequential fetch.
    step32(OP_RST, 32'h0, 32'h3000, 0, 0, 0);
    step32(OP_RST, 32'h0, 32'h3000, 0, 0, 0);
    step32(OP_F,   32'h0, 32'h3000, 1, 0, 0);
    step32(OP_F,   32'h0, 32'h3004, 1, 0, 0);
    step32(OP_F,   32'h0, 32'h3008, 1, 0, 0);
    step32(OP_F,   32'h0, 32'h300C, 1, 0, 0);
    step32(OP_F,   32'h0, 32'h3010, 1, 0, 0);
    // Stall holds pc; a branch during the stall still redirects.
    step32(OP_F | OP_S,        32'h0,    32'h3010, 1, 0, 0);
    step32(OP_F | OP_S,        32'h0,    32'h3010, 1, 0, 0);
    step32(OP_F | OP_S,        32'h0,    32'h3010, 1, 0, 0);
    step32(OP_F | OP_S | OP_B, 32'h3100, 32'h3100, 1, 0, 0);
    // Without fetch_ready the pc holds.
    step32(0,    32'h0,    32'h3100, 1, 0, 0);
    step32(OP_B, 32'h3020, 32'h3020, 1, 0, 0);
    // Exception and eret together: exception wins, epc takes the current pc.
    g_epc = 32'h3020; g_code = 2'd1;
    step32(OP_X | OP_E, 32'h0, 32'h4180, 1, 1, 0);
    step32(0,           32'h0, 32'h4180, 1, 0, 0);
    step32(OP_E,        32'h0, 32'h3020, 1, 0, 0);
    // Misaligned branch raises an address error.
    step32(OP_B, 32'h3040, 32'h3040, 1, 0, 0);
    g_epc = 32'h3040; g_bad = 32'h3102; g_code = 2'd2;
    step32(OP_B, 32'h3102, 32'h4180, 1, 1, 0);
    step32(OP_F, 32'h0,    32'h4184, 1, 0, 0);
    // Misaligned branch with external exception: external wins, badvaddr untouched.
    g_epc = 32'h4184; g_code = 2'd1;
    step32(OP_B | OP_X, 32'h3041, 32'h4180, 1, 1, 0);
    // Halt: redirects ignored while halted, resume keeps pc.
    step32(OP_B, 32'h3050, 32'h3050, 1, 0, 0);
    step32(OP_H, 32'h0,    32'h3050, 0, 0, 1);
    step32(OP_B | OP_E | OP_H | OP_F, 32'h3300, 32'h3050, 0, 0, 1);
    step32(OP_R, 32'h0,    32'h3050, 1, 0, 0);
    step32(OP_H, 32'h0,    32'h3050, 0, 0, 1);
    g_epc = 32'h3050; g_code = 2'd1;
    step32(OP_X, 32'h0,    32'h4180, 1, 1, 0);
    step32(OP_F, 32'h0,    32'h4184, 1, 0, 0);
    // Reset mid-HALT returns to BOOT; BOOT ignores requests.
    step32(OP_H, 32'h0,    32'h4184, 0, 0, 1);
    g_epc = 32'h0; g_bad = 32'h0; g_code = 2'd0;
    step32(OP_RST | OP_H, 32'h0, 32'h3000, 0, 0, 0);
    step32(OP_X | OP_B,   32'h3108, 32'h3000, 1, 0, 0);
    step32(OP_F,          32'h0,    32'h3004, 1, 0, 0);

    // Narrow instance: wrap-around from 0xFC to 0x00 and reset from 0x00.
    g_epc = 32'h0; g_bad = 32'h0; g_code = 2'd0;
    step8(OP_RST, 8'h0, 8'hFC, 0, 0, 0);
    step8(OP_F,   8'h0, 8'hFC, 1, 0, 0);
    step8(OP_F,   8'h0, 8'h00, 1, 0, 0);
    step8(OP_RST | OP_F, 8'h0, 8'hFC, 0, 0, 0);
    step8(OP_F,   8'h0, 8'hFC, 1, 0, 0);
    step8(OP_F,   8'h0, 8'h00, 1, 0, 0);
    step8(OP_F,   8'h0, 8'h04, 1, 0, 0);
    g_epc = 32'h04; g_code = 2'd1;
    step8(OP_X,   8'h0, 8'h80, 1, 1, 0);

    @(negedge clk);
    apply(0);
    repeat (3) @(negedge clk);
    checks++;
    if (q32.size() != 0 || q8.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q32.size() + q8.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the fetch stage of the MIPS core, succeeding the fixed 32-bit PC register. It holds the fetch address and provides a valid/ready handshake toward instruction memory. It applies stall, branch/jump redirect, exception entry and ERET with fixed priority. It also captures EPC and a bad address on exception, and supports a halt/resume mode.

## Interface
- WIDTH, 32: PC width in bits (≥ 8).
- RESET_VEC, 32'h0000_3000: PC value loaded on reset.
- EXC_VEC, 32'h0000_4180: exception entry address.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- fetch_ready  in  1  imem accepts pc this cycle.
- stall  in  1  hold pc (pipeline stall); does not block redirects.
- br_valid  in  1  branch/jump redirect request.
- br_target  in  WIDTH  redirect address.
- exc_req  in  1  external exception/interrupt request.
- eret  in  1  return from exception.
- halt_req  in  1  enter HALT.
- resume  in  1  leave HALT.
- pc  out  WIDTH  current fetch address.
- pc_valid  out  1  pc is a valid fetch request.
- epc  out  WIDTH  saved exception PC.
- badvaddr  out  WIDTH  faulting redirect address.
- exc_taken  out  1  one-cycle pulse: exception entered.
- exc_code  out  2  0 none, 1 external, 2 misaligned target; held until next exception.
- halted  out  1  high in HALT.

## Operation
- States: BOOT, RUN, HALT.
- Reset (any state, any cycle, overrides all inputs): state BOOT, pc=RESET_VEC, pc_valid=0, epc=0, badvaddr=0, exc_taken=0, exc_code=0, halted=0.
- BOOT: one cycle; the next state is always RUN, with pc_valid=1 and pc unchanged. All other inputs are ignored.
- RUN uses this per-cycle priority, highest first:
  - exc_req: epc←pc, pc←EXC_VEC, exc_code←1, exc_taken pulse.
  - eret: pc←epc.
  - br_valid with br_target[1:0]≠0: this is an address error. epc←pc, badvaddr←br_target, pc←EXC_VEC, exc_code←2, exc_taken pulse.
  - br_valid, aligned: pc←br_target.
  - halt_req: state HALT, pc held, pc_valid←0, halted←1.
  - fetch_ready && !stall: pc←pc+4, modulo 2^WIDTH (all-ones-minus-3 wraps to 0).
  - Otherwise: hold.
- Redirects (exception, eret, branch) are not gated by stall or fetch_ready. Any unaccepted fetch is dropped.
- HALT: pc held and pc_valid=0.
  - exc_req: take the exception as in RUN, then go to RUN with pc_valid=1.
  - Else resume: go to RUN with pc_valid=1 and pc unchanged.
  - br_valid, eret and halt_req are ignored.
- exc_taken is deasserted in every cycle without an exception entry.
- epc and badvaddr change only on exception entry. badvaddr changes only for code 2.

## Timing
- All outputs are registered. Every update is visible on the cycle after the qualifying input edge, so redirect latency is 1 cycle.
- Handshake: a fetch is accepted on a cycle with pc_valid && fetch_ready. pc advances after acceptance unless stall or a higher-priority event applies.
- exc_req and eret in the same cycle: the exception wins, and epc captures the current pc, not the old epc.
- Misaligned br_valid coinciding with exc_req: external wins, exc_code=1, badvaddr unchanged.
- Reset asserted mid-HALT or mid-exception returns to BOOT next cycle.

## Structure
- Package pc_gen_pkg holds:
  - State enum {BOOT, RUN, HALT}.
  - Exception code constants EXC_NONE=0, EXC_EXT=1, EXC_ADEL=2.
  - Increment constant PC_INC=4.
- Sub-module pc_next_sel: a combinational priority mux. It produces next pc, the epc/badvaddr load enables and the exception code from the state and inputs. The pc_gen top holds the state and output registers.

## Test plan
- Reset then run, fetch_ready=1: pc=0x3000 with pc_valid=0 for 1 cycle. Then pc=0x3000 valid, 0x3004, then 0x3008 on successive cycles.
- stall=1 for 3 cycles at pc=0x3010, then br_valid with br_target=0x3100 during the stall: pc holds 0x3010, then 0x3100 the cycle after the redirect.
- At pc=0x3020, exc_req and eret together: exc_taken=1, pc=0x4180, epc=0x3020, exc_code=1. A later eret gives pc=0x3020.
- br_valid with br_target=0x3102 at pc=0x3040: pc=0x4180, badvaddr=0x3102, epc=0x3040, exc_code=2.
- halt_req at pc=0x3050: halted=1, pc_valid=0, pc=0x3050, with br_valid ignored. resume then gives pc_valid=1 at 0x3050. Next halt, then exc_req: pc=0x4180 in RUN.
- WIDTH=8, RESET_VEC=8'hFC, fetch_ready=1: pc 0xFC then wraps to 0x00. reset asserted while pc=0x00 returns to 0xFC with pc_valid=0.
